// File: rtl/int_ack_sequencer.sv
// Interrupt acknowledge / EOI sequencer for an 8259-style PIC.
// Runs the two-pulse INTA_n handshake to fetch a vector and issues non-specific EOI writes.
module int_ack_sequencer #(
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       INT,
    input  logic [7:0] D_in,
    output logic [7:0] D_out,
    output logic       D_oe,
    output logic       INTA_n,
    output logic       CS_n,
    output logic       WR_n,
    output logic       A0,
    input  logic       int_en,
    output logic       vec_valid,
    output logic [7:0] vec,
    input  logic       vec_ready,
    input  logic       eoi_req,
    output logic       busy
);

    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] GAP_LD   = 4'(GAP_CYC - 1);
    localparam logic [7:0] EOI_CMD  = 8'h20;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACK1   = 3'd1,
        GAP    = 3'd2,
        ACK2   = 3'd3,
        VEC    = 3'd4,
        EOI_SU = 3'd5,
        EOI_WR = 3'd6,
        EOI_HD = 3'd7
    } state_t;

    state_t     state_q;
    logic       int_m_q;
    logic       int_s_q;
    logic [3:0] cnt_q;
    logic       eoi_pend_q;
    logic [7:0] d_out_q;
    logic       d_oe_q;
    logic       inta_n_q;
    logic       cs_n_q;
    logic       wr_n_q;
    logic       a0_q;
    logic       vec_valid_q;
    logic [7:0] vec_q;
    logic       busy_q;

    assign D_out     = d_out_q;
    assign D_oe      = d_oe_q;
    assign INTA_n    = inta_n_q;
    assign CS_n      = cs_n_q;
    assign WR_n      = wr_n_q;
    assign A0        = a0_q;
    assign vec_valid = vec_valid_q;
    assign vec       = vec_q;
    assign busy      = busy_q;

    // Two-flop synchronizer for the asynchronous INT request.
    always_ff @(posedge clk) begin
        if (reset) begin
            int_m_q <= 1'b0;
            int_s_q <= 1'b0;
        end else begin
            int_m_q <= INT;
            int_s_q <= int_m_q;
        end
    end

    // Sequencer FSM; every bus output is a register updated on the transition into its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            eoi_pend_q  <= 1'b0;
            d_out_q     <= 8'h00;
            d_oe_q      <= 1'b0;
            inta_n_q    <= 1'b1;
            cs_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            a0_q        <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_q       <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            // EOI requests seen while busy are remembered; the IDLE branch below clears the flag.
            eoi_pend_q <= eoi_pend_q | (eoi_req & (state_q != IDLE));
            case (state_q)
                IDLE: begin
                    if (eoi_req || eoi_pend_q) begin
                        state_q    <= EOI_SU;
                        eoi_pend_q <= 1'b0;
                        cs_n_q     <= 1'b0;
                        a0_q       <= 1'b0;
                        d_oe_q     <= 1'b1;
                        d_out_q    <= EOI_CMD;
                        wr_n_q     <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (int_s_q && int_en) begin
                        state_q  <= ACK1;
                        inta_n_q <= 1'b0;
                        cnt_q    <= PULSE_LD;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACK1: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= GAP;
                        inta_n_q <= 1'b1;
                        cnt_q    <= GAP_LD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= ACK2;
                        inta_n_q <= 1'b0;
                        cnt_q    <= PULSE_LD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ACK2: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= VEC;
                        inta_n_q    <= 1'b1;
                        vec_q       <= D_in;
                        vec_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                VEC: begin
                    if (vec_ready) begin
                        state_q     <= IDLE;
                        vec_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else begin
                        state_q <= VEC;
                    end
                end
                EOI_SU: begin
                    state_q <= EOI_WR;
                    wr_n_q  <= 1'b0;
                    cnt_q   <= PULSE_LD;
                end
                EOI_WR: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= EOI_HD;
                        wr_n_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                EOI_HD: begin
                    state_q <= IDLE;
                    cs_n_q  <= 1'b1;
                    d_oe_q  <= 1'b0;
                    d_out_q <= 8'h00;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    inta_n_q    <= 1'b1;
                    wr_n_q      <= 1'b1;
                    cs_n_q      <= 1'b1;
                    d_oe_q      <= 1'b0;
                    vec_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ack_sequencer.sv
// Directed self-checking bench for int_ack_sequencer at default timing (4/4).
// A cycle table covers the basic acknowledge; short sequences cover EOI, gating and reset.
module tb_int_ack_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       INT;
    logic [7:0] D_in;
    logic [7:0] D_out;
    logic       D_oe;
    logic       INTA_n;
    logic       CS_n;
    logic       WR_n;
    logic       A0;
    logic       int_en;
    logic       vec_valid;
    logic [7:0] vec;
    logic       vec_ready;
    logic       eoi_req;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int overlap = 0;

    int_ack_sequencer #(.PULSE_CYC(4), .GAP_CYC(4)) dut (
        .clk(clk), .reset(reset), .INT(INT), .D_in(D_in), .D_out(D_out), .D_oe(D_oe),
        .INTA_n(INTA_n), .CS_n(CS_n), .WR_n(WR_n), .A0(A0), .int_en(int_en),
        .vec_valid(vec_valid), .vec(vec), .vec_ready(vec_ready), .eoi_req(eoi_req), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (INTA_n === 1'b0 && WR_n === 1'b0) overlap++;
    end

    typedef struct {
        logic       int_in;
        logic [7:0] d;
        logic       rdy;
        logic       e_inta;
        logic       e_vv;
        logic       e_busy;
    } row_t;

    row_t tbl[36];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " INTA_n"}, {31'd0, INTA_n}, 32'd1);
        chk({tag, " WR_n"}, {31'd0, WR_n}, 32'd1);
        chk({tag, " CS_n"}, {31'd0, CS_n}, 32'd1);
        chk({tag, " A0"}, {31'd0, A0}, 32'd0);
        chk({tag, " D_oe"}, {31'd0, D_oe}, 32'd0);
        chk({tag, " D_out"}, {24'd0, D_out}, 32'd0);
        chk({tag, " vec"}, {24'd0, vec}, 32'd0);
        chk({tag, " vec_valid"}, {31'd0, vec_valid}, 32'd0);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cs_cnt;
        int wr_cnt;
        int bad;

        // Basic acknowledge: INT applied before edge 1, int_s high after edge 2.
        for (int k = 1; k <= 36; k++) begin
            tbl[k-1].int_in = (k < 8);
            tbl[k-1].d      = (k == 15) ? 8'hA8 : ((k > 15) ? 8'hFF : 8'h00);
            tbl[k-1].rdy    = (k == 35);
            tbl[k-1].e_inta = ((k >= 3 && k <= 6) || (k >= 11 && k <= 14)) ? 1'b0 : 1'b1;
            tbl[k-1].e_vv   = (k >= 15 && k <= 34);
            tbl[k-1].e_busy = (k >= 3 && k <= 34);
        end

        reset = 1'b1; INT = 1'b0; D_in = 8'h00; int_en = 1'b1; vec_ready = 1'b0; eoi_req = 1'b0;
        repeat (3) tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();

        for (int k = 1; k <= 36; k++) begin
            INT = tbl[k-1].int_in;
            D_in = tbl[k-1].d;
            vec_ready = tbl[k-1].rdy;
            tick();
            chk($sformatf("tbl%0d INTA_n", k), {31'd0, INTA_n}, {31'd0, tbl[k-1].e_inta});
            chk($sformatf("tbl%0d vec_valid", k), {31'd0, vec_valid}, {31'd0, tbl[k-1].e_vv});
            chk($sformatf("tbl%0d busy", k), {31'd0, busy}, {31'd0, tbl[k-1].e_busy});
            chk($sformatf("tbl%0d CS_n", k), {31'd0, CS_n}, 32'd1);
            if (tbl[k-1].e_vv) chk($sformatf("tbl%0d vec", k), {24'd0, vec}, 32'hA8);
        end
        vec_ready = 1'b0;

        // EOI requested during ACK2 waits for the vector handshake.
        cs_cnt = 0; wr_cnt = 0; bad = 0; D_in = 8'hA8;
        for (int k = 1; k <= 24; k++) begin
            INT = (k < 8);
            eoi_req = (k == 12);
            vec_ready = (k == 16);
            tick();
            if (!CS_n) begin
                cs_cnt++;
                if (D_out !== 8'h20 || A0 !== 1'b0 || D_oe !== 1'b1) bad++;
            end
            if (!WR_n) wr_cnt++;
            if (k == 15) begin
                chk("eoiack vv", {31'd0, vec_valid}, 32'd1);
                chk("eoiack cs_in_vec", {31'd0, CS_n}, 32'd1);
            end
            if (k == 16) chk("eoiack cs_after_rdy", {31'd0, CS_n}, 32'd1);
            if (k == 17) begin
                chk("eoi_su cs", {31'd0, CS_n}, 32'd0);
                chk("eoi_su wr", {31'd0, WR_n}, 32'd1);
                chk("eoi_su dout", {24'd0, D_out}, 32'h20);
            end
            if (k == 22) chk("eoi_hd wr", {31'd0, WR_n}, 32'd1);
            if (k == 23) begin
                chk("eoi_end cs", {31'd0, CS_n}, 32'd1);
                chk("eoi_end doe", {31'd0, D_oe}, 32'd0);
                chk("eoi_end busy", {31'd0, busy}, 32'd0);
            end
        end
        eoi_req = 1'b0; vec_ready = 1'b0;
        chk("eoi cs cycles", cs_cnt, 32'd6);
        chk("eoi wr cycles", wr_cnt, 32'd4);
        chk("eoi bus values", bad, 32'd0);

        // EOI and int_s in the same IDLE cycle: EOI first, then ACK1.
        for (int k = 1; k <= 24; k++) begin
            INT = (k < 11);
            eoi_req = (k == 3);
            vec_ready = (k == 23);
            tick();
            if (k == 3) begin
                chk("prio cs", {31'd0, CS_n}, 32'd0);
                chk("prio inta", {31'd0, INTA_n}, 32'd1);
            end
            if (k == 9) chk("prio idle cs", {31'd0, CS_n}, 32'd1);
            if (k == 10) chk("prio ack1", {31'd0, INTA_n}, 32'd0);
            if (k == 22) chk("prio vv", {31'd0, vec_valid}, 32'd1);
            if (k == 24) chk("prio idle", {31'd0, busy}, 32'd0);
        end
        eoi_req = 1'b0; vec_ready = 1'b0;

        // int_en gating, then reset during GAP.
        int_en = 1'b0; bad = 0;
        for (int k = 1; k <= 16; k++) begin
            INT = (k < 16);
            int_en = (k >= 11);
            reset = (k == 16);
            tick();
            if (k <= 10 && (INTA_n !== 1'b1 || busy !== 1'b0)) bad++;
            if (k == 11) chk("en ack1", {31'd0, INTA_n}, 32'd0);
            if (k == 15) chk("gap inta", {31'd0, INTA_n}, 32'd1);
        end
        chk("gated no ack", bad, 32'd0);
        chk_reset_vals("midreset");
        reset = 1'b0; bad = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (vec_valid !== 1'b0 || busy !== 1'b0 || CS_n !== 1'b1 || INTA_n !== 1'b1) bad++;
        end
        chk("post reset quiet", bad, 32'd0);
        chk("inta wr overlap", overlap, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/int_ack_sequencer.md
INT_ACK_SEQUENCER -- requirements
Module: int_ack_sequencer

Interface
REQ-001 Parameter PULSE_CYC, default 4: clk cycles INTA_n or WR_n is held low per pulse, legal range 1..15.
REQ-002 Parameter GAP_CYC, default 4: clk cycles INTA_n is held high between the two acknowledge pulses, legal range 1..15.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port INT  input  1  interrupt request from the PIC, asynchronous to clk.
REQ-006 Port D_in  input  8  PIC data bus as read back; carries the vector during the second acknowledge.
REQ-007 Port D_out  output  8  value driven onto the PIC data bus during an EOI write.
REQ-008 Port D_oe  output  1  high while D_out must be driven onto the bus.
REQ-009 Port INTA_n  output  1  interrupt acknowledge to the PIC, active low.
REQ-010 Port CS_n  output  1  chip select to the PIC, active low.
REQ-011 Port WR_n  output  1  write strobe to the PIC, active low.
REQ-012 Port A0  output  1  address line to the PIC.
REQ-013 Port int_en  input  1  CPU interrupt enable; gates the start of a new acknowledge sequence.
REQ-014 Port vec_valid  output  1  captured vector available.
REQ-015 Port vec  output  8  captured interrupt vector.
REQ-016 Port vec_ready  input  1  CPU accepts the vector.
REQ-017 Port eoi_req  input  1  single-cycle request to issue a non-specific EOI.
REQ-018 Port busy  output  1  high in every state except IDLE.

Function
REQ-019 INT shall pass through a two-flop synchronizer; int_s is the second-stage output; all decisions shall use int_s only.
REQ-020 States shall be IDLE, ACK1, GAP, ACK2, VEC, EOI_SU, EOI_WR, EOI_HD; a single down-counter (4 bits) shall time ACK1, GAP, ACK2 and EOI_WR.
REQ-021 IDLE, with eoi_req=1 (or eoi_pend=1) -> EOI_SU; this takes priority over an interrupt start in the same cycle.
REQ-022 IDLE, with int_s=1, int_en=1 and no EOI pending -> ACK1.
REQ-023 eoi_req arriving in any non-IDLE state shall set an eoi_pend flag; eoi_pend shall clear on entry to EOI_SU; further requests while pending shall be merged into it.
REQ-024 ACK1: INTA_n=0 for PULSE_CYC cycles, then -> GAP.
REQ-025 GAP: INTA_n=1 for GAP_CYC cycles, then -> ACK2.
REQ-026 ACK2: INTA_n=0 for PULSE_CYC cycles; D_in shall be captured into vec on the last ACK2 cycle; the next state is VEC.
REQ-027 Once ACK1 is entered, the sequence shall complete even if int_s falls; the vector is whatever the PIC drives (spurious IR7 is the CPU's concern).
REQ-028 VEC: vec_valid=1 and vec held stable until the cycle vec_ready=1, then -> IDLE.
REQ-029 Re-acknowledge is level-based: if int_s is still 1 in IDLE, a new sequence shall start on the next cycle.
REQ-030 Latency from int_s=1 in IDLE to vec_valid=1 shall be 1+2*PULSE_CYC+GAP_CYC cycles (13 at defaults).
REQ-031 EOI_SU: 1 cycle; CS_n=0, A0=0, D_oe=1, D_out=8'h20, WR_n=1.
REQ-032 EOI_WR: same bus values with WR_n=0 for PULSE_CYC cycles.
REQ-033 EOI_HD: 1 cycle; WR_n=1 with CS_n, A0, D_oe and D_out held, then -> IDLE with CS_n=1 and D_oe=0.
REQ-034 INTA_n and WR_n shall never be low in the same cycle; CS_n=1 in all non-EOI states; all bus outputs shall be registered.

Reset
REQ-035 Reset shall force IDLE, INTA_n=1, WR_n=1, CS_n=1, A0=0, D_oe=0, D_out=0, vec=0, vec_valid=0, busy=0, eoi_pend=0, counter=0 and synchronizer flops=0.
REQ-036 Reset asserted mid-sequence shall release INTA_n or WR_n high on the next edge; no vector or EOI is reported after reset.

Verification
REQ-037 Bench: INT rise with int_en=1, PIC base 10101xxx, IR0 -> two 4-cycle INTA_n lows 4 cycles apart; vec=8'hA8; vec_valid 13 cycles after int_s.
REQ-038 Bench: vec_ready held 0 for 20 cycles -> vec_valid and vec=8'hA8 remain stable; IDLE follows the cycle after vec_ready=1.
REQ-039 Bench: eoi_req during ACK2 -> vector handshake completes first, then CS_n/A0=0, D_out=8'h20 for 6 cycles with WR_n low 4 cycles.
REQ-040 Bench: eoi_req and int_s=1 in the same IDLE cycle -> EOI sequence first, then ACK1.
REQ-041 Bench: int_en=0 with INT high -> INTA_n stays 1; int_en set -> ACK1 within 1 cycle.
REQ-042 Bench: reset during GAP -> all outputs at reset values next cycle; no vec_valid.
